// File: rtl/disp_wr_sched.sv
// disp_wr_sched: schedules the display-memory write port between two round-robin writers and a fill engine.
// Define DISP_WR_SCHED_EOF_GATE_EN to hold a requested clear until the next end-of-frame pulse.
module disp_wr_sched #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              clear_start_i,
  input  logic [ADDR_W-1:0] clear_base_i,
  input  logic [ADDR_W-1:0] clear_len_i,
  input  logic [DATA_W-1:0] clear_data_i,
  input  logic              eof_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef DISP_WR_SCHED_EOF_GATE_EN
  localparam logic [1:0] ST_ARMED = 2'd1;
`endif
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic serve, accept0, accept1, clearLast;

  // lastGrant_q = 1 means req1 won most recently, so req0 wins the next tie
  assign serve        = (state_q != ST_CLEAR);
  assign req0_ready_o = serve && (!req1_valid_i || lastGrant_q);
  assign req1_ready_o = serve && (!req0_valid_i || !lastGrant_q);
  assign accept0      = req0_valid_i && req0_ready_o;
  assign accept1      = req1_valid_i && req1_ready_o;

  // len 0 sweeps the whole space: offset ends at all-ones, which is len-1 modulo 2**ADDR_W
  assign clearLast = (offset_q == len_q - ADDR_W'(1));

`ifndef DISP_WR_SCHED_EOF_GATE_EN
  logic unused_signals;
  assign unused_signals = eof_i;
`endif

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    base_d      = base_q;
    len_d       = len_q;
    fill_d      = fill_q;
    offset_d    = offset_q;
    wrEn_d      = 1'b0;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_start_i) begin
          base_d   = clear_base_i;
          len_d    = clear_len_i;
          fill_d   = clear_data_i;
          offset_d = '0;
`ifdef DISP_WR_SCHED_EOF_GATE_EN
          state_d  = ST_ARMED;
`else
          state_d  = ST_CLEAR;
`endif
        end
      end
`ifdef DISP_WR_SCHED_EOF_GATE_EN
      ST_ARMED: begin
        if (eof_i) state_d = ST_CLEAR;
      end
`endif
      ST_CLEAR: begin
        wrEn_d   = 1'b1;
        wrAddr_d = base_q + offset_q;
        wrData_d = fill_q;
        offset_d = offset_q + ADDR_W'(1);
        if (clearLast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requesters are never ready during CLEAR, so this cannot collide with a fill write
    if (accept0) begin
      wrEn_d      = 1'b1;
      wrAddr_d    = req0_addr_i;
      wrData_d    = req0_data_i;
      lastGrant_d = 1'b0;
    end else if (accept1) begin
      wrEn_d      = 1'b1;
      wrAddr_d    = req1_addr_i;
      wrData_d    = req1_data_i;
      lastGrant_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= 1'b1;
      base_q      <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      offset_q    <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      base_q      <= base_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      offset_q    <= offset_d;
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en_o      = wrEn_q;
  assign wr_addr_o    = wrAddr_q;
  assign wr_data_o    = wrData_q;
  assign clear_done_o = done_q;
  assign clear_busy_o = busy_q;

endmodule

// File: tb/tb_disp_wr_sched.sv
// tb_disp_wr_sched: directed stimulus for disp_wr_sched, checked every cycle against a transaction-level model.
// Honours DISP_WR_SCHED_EOF_GATE_EN the same way as the design.
module tb_disp_wr_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [13:0] req0_addr = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [13:0] req1_addr = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        clear_start = 1'b0;
  logic [13:0] clear_base = '0;
  logic [13:0] clear_len = '0;
  logic [15:0] clear_data = '0;
  logic        eof = 1'b0;
  logic        clear_busy;
  logic        clear_done;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;

  disp_wr_sched #(.ADDR_W(14), .DATA_W(16)) dut (
    .clk          (clk),
    .reset_i      (reset),
    .req0_valid_i (req0_valid),
    .req0_addr_i  (req0_addr),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_addr_i  (req1_addr),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .clear_start_i(clear_start),
    .clear_base_i (clear_base),
    .clear_len_i  (clear_len),
    .clear_data_i (clear_data),
    .eof_i        (eof),
    .clear_busy_o (clear_busy),
    .clear_done_o (clear_done),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a clear is a count of words still to write plus the next address; no state encoding
  int          mLeft;
  int          mPendLen;
  logic        mArmed;
  logic [13:0] mClrAddr;
  logic [15:0] mClrWord;
  logic        mReq1WonLast;
  logic        mServe, mGrant0, mGrant1;
  logic        expWrEn, expDone, expBusy;
  logic [13:0] expAddr;
  logic [15:0] expData;

  always_comb begin
    mServe  = (mLeft == 0);
    mGrant0 = mServe && req0_valid && (!req1_valid || mReq1WonLast);
    mGrant1 = mServe && req1_valid && (!req0_valid || !mReq1WonLast);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLeft <= 0; mPendLen <= 0; mArmed <= 1'b0; mClrAddr <= '0; mClrWord <= '0;
      mReq1WonLast <= 1'b1;
      expWrEn <= 1'b0; expDone <= 1'b0; expBusy <= 1'b0; expAddr <= '0; expData <= '0;
    end else begin
      expWrEn <= (mLeft > 0) || mGrant0 || mGrant1;
      expDone <= (mLeft == 1);
      if (mLeft > 0) begin
        expAddr  <= mClrAddr;
        expData  <= mClrWord;
        mClrAddr <= mClrAddr + 14'd1;
        mLeft    <= mLeft - 1;
        expBusy  <= (mLeft > 1);
      end else begin
        if (mGrant0) begin
          expAddr <= req0_addr; expData <= req0_data; mReq1WonLast <= 1'b0;
        end else if (mGrant1) begin
          expAddr <= req1_addr; expData <= req1_data; mReq1WonLast <= 1'b1;
        end
        if (mArmed) begin
          expBusy <= 1'b1;
          if (eof) begin
            mArmed <= 1'b0;
            mLeft  <= mPendLen;
          end
        end else if (clear_start) begin
          mClrAddr <= clear_base;
          mClrWord <= clear_data;
          expBusy  <= 1'b1;
`ifdef DISP_WR_SCHED_EOF_GATE_EN
          mArmed   <= 1'b1;
          mPendLen <= (clear_len == 14'd0) ? 16384 : int'(clear_len);
`else
          mLeft    <= (clear_len == 14'd0) ? 16384 : int'(clear_len);
`endif
        end else begin
          expBusy <= 1'b0;
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the model
  always @(negedge clk) begin
    checkOutput("cmp_ready0", 32'(req0_ready), 32'(mServe && (!req1_valid || mReq1WonLast)));
    checkOutput("cmp_ready1", 32'(req1_ready), 32'(mServe && (!req0_valid || !mReq1WonLast)));
    checkOutput("cmp_wr_en", 32'(wr_en), 32'(expWrEn));
    checkOutput("cmp_wr_addr", 32'(wr_addr), 32'(expAddr));
    checkOutput("cmp_wr_data", 32'(wr_data), 32'(expData));
    checkOutput("cmp_busy", 32'(clear_busy), 32'(expBusy));
    checkOutput("cmp_done", 32'(clear_done), 32'(expDone));
  end

  task automatic applyStimulus(input logic [13:0] base, input logic [13:0] len, input logic [15:0] word);
    clear_base  = base;
    clear_len   = len;
    clear_data  = word;
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    req0_valid  = 1'b0;
`ifdef DISP_WR_SCHED_EOF_GATE_EN
    eof = 1'b1;
    tick;
    eof = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grantSeq[6];
    logic [13:0] clrAddrs[4];
    int wrCount, stall, busyCount, writes;
    logic sawDone;
    logic [13:0] lastAddr;
    grantSeq = '{0, 1, 0, 1, 0, 1};
    clrAddrs = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_busy", 32'(clear_busy), 32'd0);
    checkOutput("rst_done", 32'(clear_done), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd1);

    // Single write from req0
    req0_valid = 1'b1; req0_addr = 14'h010; req0_data = 16'h1234;
    #1 checkOutput("single_ready0", 32'(req0_ready), 32'd1);
    tick;
    req0_valid = 1'b0;
    checkOutput("single_wr_en", 32'(wr_en), 32'd1);
    checkOutput("single_wr_addr", 32'(wr_addr), 32'h010);
    checkOutput("single_wr_data", 32'(wr_data), 32'h1234);
    tick;
    checkOutput("single_idle_wr_en", 32'(wr_en), 32'd0);
    checkOutput("single_hold_addr", 32'(wr_addr), 32'h010);

    // Asynchronous reset in the middle of contended traffic
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 14'h020; req1_addr = 14'h021;
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_ready0", 32'(req0_ready), 32'd1);
    checkOutput("midrst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Round robin with both valid, req0 wins the first tie after reset
    wrCount = 0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_addr = 14'(i); req0_data = 16'hA000 + 16'(i);
      req1_valid = 1'b1; req1_addr = 14'h100 + 14'(i); req1_data = 16'hB000 + 16'(i);
      #1 checkOutput("rr_ready0", 32'(req0_ready), 32'(grantSeq[i] == 0));
      tick;
      if (wr_en) wrCount++;
      checkOutput("rr_wr_data", 32'(wr_data),
                  (grantSeq[i] == 0) ? 32'hA000 + 32'(i) : 32'hB000 + 32'(i));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rr_wr_en_count", 32'(wrCount), 32'd6);

    // Clear wrapping past the top of the address space, with a req0 write in the start cycle
    req0_valid = 1'b1; req0_addr = 14'h055; req0_data = 16'h5555;
    clear_base = 14'h3FFE; clear_len = 14'd4; clear_data = 16'h0020; clear_start = 1'b1;
    tick;
    clear_start = 1'b0; req0_valid = 1'b0;
    checkOutput("wrap_samecyc_wr_en", 32'(wr_en), 32'd1);
    checkOutput("wrap_samecyc_addr", 32'(wr_addr), 32'h055);
    checkOutput("wrap_busy", 32'(clear_busy), 32'd1);
`ifdef DISP_WR_SCHED_EOF_GATE_EN
    eof = 1'b1;
    tick;
    eof = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("wrap_wr_en", 32'(wr_en), 32'd1);
      checkOutput("wrap_wr_addr", 32'(wr_addr), 32'(clrAddrs[i]));
      checkOutput("wrap_wr_data", 32'(wr_data), 32'h0020);
      checkOutput("wrap_done", 32'(clear_done), 32'(i == 3));
    end
    checkOutput("wrap_busy_end", 32'(clear_busy), 32'd0);
    tick;
    checkOutput("wrap_done_pulse", 32'(clear_done), 32'd0);

    // req1 stalls while a 3-word clear runs
    applyStimulus(14'h0200, 14'd3, 16'h7777);
    req1_valid = 1'b1; req1_addr = 14'h0AA; req1_data = 16'hBEEF;
    stall = 0; busyCount = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req1_ready) break;
      stall++;
      if (clear_busy) busyCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("stall_cycles", 32'(stall), 32'd3);
    checkOutput("stall_busy_cycles", 32'(busyCount), 32'd3);
    tick;
    req1_valid = 1'b0;
    checkOutput("stall_accept_data", 32'(wr_data), 32'hBEEF);
    checkOutput("stall_accept_addr", 32'(wr_addr), 32'h0AA);

    // len 0 fills every address once
    applyStimulus(14'h1234, 14'd0, 16'h00FF);
    writes = 0; sawDone = 1'b0; lastAddr = '0;
    for (int k = 0; k < 20000; k++) begin
      tick;
      if (wr_en) writes++;
      if (clear_done) begin
        sawDone = 1'b1;
        lastAddr = wr_addr;
        break;
      end
    end
    checkOutput("full_done_seen", 32'(sawDone), 32'd1);
    checkOutput("full_write_count", 32'(writes), 32'd16384);
    checkOutput("full_last_addr", 32'(lastAddr), 32'h1233);
    tick;

`ifdef DISP_WR_SCHED_EOF_GATE_EN
    // Gated clear: eof in the start cycle is ignored, traffic flows while armed
    clear_base = 14'h0100; clear_len = 14'd2; clear_data = 16'h0F0F;
    clear_start = 1'b1; eof = 1'b1;
    tick;
    clear_start = 1'b0; eof = 1'b0;
    checkOutput("gate_busy_armed", 32'(clear_busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req0_addr = 14'h300 + 14'(i); req0_data = 16'hC000 + 16'(i);
      #1 checkOutput("gate_ready0", 32'(req0_ready), 32'd1);
      tick;
      checkOutput("gate_req_data", 32'(wr_data), 32'hC000 + 32'(i));
    end
    req0_addr = 14'h30A; req0_data = 16'hC00A; eof = 1'b1;
    #1 checkOutput("gate_eof_ready0", 32'(req0_ready), 32'd1);
    tick;
    eof = 1'b0; req0_valid = 1'b0;
    checkOutput("gate_eof_req_addr", 32'(wr_addr), 32'h30A);
    tick;
    checkOutput("gate_first_clr_en", 32'(wr_en), 32'd1);
    checkOutput("gate_first_clr_addr", 32'(wr_addr), 32'h100);
    tick;
    checkOutput("gate_last_clr_addr", 32'(wr_addr), 32'h101);
    checkOutput("gate_done", 32'(clear_done), 32'd1);
`else
    // Without gating, eof alone must not start anything
    eof = 1'b1;
    tick;
    eof = 1'b0;
    tick;
    checkOutput("eof_ignored_busy", 32'(clear_busy), 32'd0);
    checkOutput("eof_ignored_wr_en", 32'(wr_en), 32'd0);
`endif

    tick;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
